dzcpu_uop_sequencer: RTL and testbench

- Micro-op sequencer for the dzcpu core; the consumer of the opcode→flow-index LUTs and the micro-op ROM.
- Latches each fetched opcode, drives it to the main and CB LUTs, and walks the ROM address through the selected flow until an end-of-flow code.
- Produces per-uop control strobes (PC increment, flag update, instruction retire) for the datapath.
- Also redirects to the interrupt flow at instruction boundaries and guards against runaway flows.

---
 rtl/dzcpu_uop_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_dzcpu_uop_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-op sequencer: latches opcodes, walks the micro-op ROM through
// the selected flow and emits per-uop PC/flag/retire/interrupt strobes.
//
// Ports:
//   iClock, iReset          clock, asynchronous active-high reset
//   iMemData                opcode / CB byte at the current PC
//   iStall                  freezes the sequencer, gates all strobes
//   iZFlag                  Z flag for conditional end-of-flow uops
//   iIntPending, iIme       pending enabled interrupt, master enable
//   oMop                    latched opcode driven to main and CB LUTs
//   iFlowIdx, iCbFlowIdx    main / CB LUT flow start addresses
//   oRomAddr, iUop          micro-op ROM address and returned word
//   oUop, oUopValid         executing uop (zero when not valid)
//   oPcInc, oFlagUpdate     datapath strobes
//   oEof, oIntAck           instruction retire, interrupt taken
//   oFault                  sticky runaway-flow flag
module dzcpu_uop_sequencer #(
    parameter logic [7:0] INT_FLOW_IDX = 8'd202,
    parameter logic [4:0] JCB_OP       = 5'd1,
    parameter int         MAX_FLOW_LEN = 32
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iMemData,
    input  logic        iStall,
    input  logic        iZFlag,
    input  logic        iIntPending,
    input  logic        iIme,
    output logic [7:0]  oMop,
    input  logic [7:0]  iFlowIdx,
    input  logic [7:0]  iCbFlowIdx,
    output logic [7:0]  oRomAddr,
    input  logic [12:0] iUop,
    output logic [12:0] oUop,
    output logic        oUopValid,
    output logic        oPcInc,
    output logic        oFlagUpdate,
    output logic        oEof,
    output logic        oIntAck,
    output logic        oFault
);

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        CBDECODE,
        EXEC
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_FLOW_LEN - 1);

    state_t     state_q, state_nx;
    logic [7:0] mop_q, mop_nx;
    logic [7:0] addr_q, addr_nx;
    logic [7:0] cnt_q, cnt_nx;
    logic       fault_q, fault_nx;

    logic [3:0] nxt;
    logic [4:0] op;
    logic       dec_inc;
    logic       dec_fu;
    logic       dec_end;

    assign nxt = iUop[12:9];
    assign op  = iUop[8:4];

    // Next-field decode; codes 9..15 behave as a plain OP.
    always_comb begin
        dec_inc = 1'b0;
        dec_fu  = 1'b0;
        dec_end = 1'b0;
        case (nxt)
            4'd1: dec_inc = 1'b1;
            4'd2: dec_end = 1'b1;
            4'd3: begin
                dec_inc = 1'b1;
                dec_end = 1'b1;
            end
            4'd4: begin
                dec_fu  = 1'b1;
                dec_end = 1'b1;
            end
            4'd5: begin
                dec_inc = 1'b1;
                dec_fu  = 1'b1;
                dec_end = 1'b1;
            end
            4'd6: begin
                dec_inc = 1'b1;
                dec_end = iZFlag;
            end
            4'd7: begin
                dec_inc = 1'b1;
                dec_end = ~iZFlag;
            end
            4'd8: dec_fu = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nx    = state_q;
        mop_nx      = mop_q;
        addr_nx     = addr_q;
        cnt_nx      = cnt_q;
        fault_nx    = fault_q;
        oUopValid   = 1'b0;
        oPcInc      = 1'b0;
        oFlagUpdate = 1'b0;
        oEof        = 1'b0;
        oIntAck     = 1'b0;
        if (!iStall) begin
            unique case (state_q)
                FETCH: begin
                    // Interrupts are only taken between instructions.
                    if (iIntPending && iIme) begin
                        oIntAck  = 1'b1;
                        addr_nx  = INT_FLOW_IDX;
                        cnt_nx   = '0;
                        state_nx = EXEC;
                    end else begin
                        mop_nx   = iMemData;
                        state_nx = DECODE;
                    end
                end
                DECODE: begin
                    addr_nx  = iFlowIdx;
                    cnt_nx   = '0;
                    state_nx = EXEC;
                end
                CBDECODE: begin
                    addr_nx  = iCbFlowIdx;
                    cnt_nx   = '0;
                    state_nx = EXEC;
                end
                EXEC: begin
                    oUopValid   = 1'b1;
                    oPcInc      = dec_inc;
                    oFlagUpdate = dec_fu;
                    if (dec_end) begin
                        oEof     = 1'b1;
                        state_nx = FETCH;
                    end else if (cnt_q == LAST_CNT) begin
                        // Runaway flow: abandon it without retiring.
                        fault_nx = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        addr_nx = addr_q + 8'd1;
                        cnt_nx  = cnt_q + 8'd1;
                        if (op == JCB_OP) begin
                            mop_nx   = iMemData;
                            state_nx = CBDECODE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= FETCH;
            mop_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            mop_q   <= mop_nx;
            addr_q  <= addr_nx;
            cnt_q   <= cnt_nx;
            fault_q <= fault_nx;
        end
    end

    assign oMop     = mop_q;
    assign oRomAddr = addr_q;
    assign oFault   = fault_q;
    assign oUop     = oUopValid ? iUop : 13'd0;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer with behavioural LUT and ROM models.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dzcpu_uop_sequencer;

    logic        iClock;
    logic        iReset;
    logic [7:0]  iMemData;
    logic        iStall;
    logic        iZFlag;
    logic        iIntPending;
    logic        iIme;
    logic [7:0]  oMop;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx;
    logic [7:0]  oRomAddr;
    logic [12:0] iUop;
    logic [12:0] oUop;
    logic        oUopValid;
    logic        oPcInc;
    logic        oFlagUpdate;
    logic        oEof;
    logic        oIntAck;
    logic        oFault;

    logic [12:0] rom   [256];
    logic [7:0]  lut   [256];
    logic [7:0]  cblut [256];

    int n_cmp = 0;
    int n_err = 0;

    // {addr, valid, pcinc, flagupd, eof, intack}
    wire [12:0] obs = {oRomAddr, oUopValid, oPcInc, oFlagUpdate, oEof, oIntAck};

    assign iUop       = rom[oRomAddr];
    assign iFlowIdx   = lut[oMop];
    assign iCbFlowIdx = cblut[oMop];

    dzcpu_uop_sequencer dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iMemData    (iMemData),
        .iStall      (iStall),
        .iZFlag      (iZFlag),
        .iIntPending (iIntPending),
        .iIme        (iIme),
        .oMop        (oMop),
        .iFlowIdx    (iFlowIdx),
        .iCbFlowIdx  (iCbFlowIdx),
        .oRomAddr    (oRomAddr),
        .iUop        (iUop),
        .oUop        (oUop),
        .oUopValid   (oUopValid),
        .oPcInc      (oPcInc),
        .oFlagUpdate (oFlagUpdate),
        .oEof        (oEof),
        .oIntAck     (oIntAck),
        .oFault      (oFault)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    function automatic logic [12:0] u(input logic [3:0] n, input logic [4:0] o);
        return {n, o, 4'h0};
    endfunction

    // Release the stall in FETCH with an opcode; return at the first uop.
    task automatic start(input logic [7:0] opc);
        iMemData = opc;
        iStall   = 1'b0;
        @(negedge iClock);
        @(negedge iClock);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({oMop, oRomAddr, oFault, oUop, obs[4:0]} !== 39'd0) begin
            n_err++;
            $display("FAIL reset: mop=%h addr=%h fault=%b uop=%h strb=%b want all 0",
                     oMop, oRomAddr, oFault, oUop, obs[4:0]);
        end
        @(negedge iClock);
        iReset = 1'b0;
    endtask

    task automatic test_basic();
        logic [12:0] ex [4];
        ex = '{{8'd1, 5'b11000}, {8'd2, 5'b11000},
               {8'd3, 5'b10000}, {8'd4, 5'b11010}};
        start(8'h31);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL basic[%0d]: got %h want %h", i, obs, ex[i]);
            end
            @(negedge iClock);
        end
        n_cmp++;
        if (obs[4:0] !== 5'b0 || oMop !== 8'h31) begin
            n_err++;
            $display("FAIL basic_fetch: strb=%b mop=%h want 00000 31", obs[4:0], oMop);
        end
        iStall = 1'b1;
    endtask

    task automatic test_jrnz(input logic z);
        logic [12:0] ex [$];
        if (z)
            ex = '{{8'd17, 5'b11000}, {8'd18, 5'b10000}, {8'd19, 5'b11010}};
        else
            ex = '{{8'd17, 5'b11000}, {8'd18, 5'b10000}, {8'd19, 5'b11000},
                   {8'd20, 5'b10000}, {8'd21, 5'b10000}, {8'd22, 5'b10010}};
        iZFlag = z;
        start(8'h20);
        foreach (ex[i]) begin
            n_cmp++;
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL jrnz_z%0d[%0d]: got %h want %h", z, i, obs, ex[i]);
            end
            @(negedge iClock);
        end
        iStall = 1'b1;
        iZFlag = 1'b0;
    endtask

    task automatic test_cb();
        logic [12:0] ex [3];
        ex = '{{8'd13, 5'b11000}, {8'd14, 5'b10000}, {8'd15, 5'b11000}};
        iMemData = 8'hCB;
        iStall   = 1'b0;
        @(negedge iClock);
        iMemData = 8'h7C;
        @(negedge iClock);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL cb[%0d]: got %h want %h", i, obs, ex[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (oUop !== 13'h0210) begin
                    n_err++;
                    $display("FAIL cb_uop: got %h want 0210", oUop);
                end
            end
            @(negedge iClock);
        end
        n_cmp++;
        if (obs[4:0] !== 5'b0 || oMop !== 8'h7C) begin
            n_err++;
            $display("FAIL cbdecode: strb=%b mop=%h want 00000 7c", obs[4:0], oMop);
        end
        @(negedge iClock);
        n_cmp++;
        if (obs !== {8'd16, 5'b10110}) begin
            n_err++;
            $display("FAIL cb_flow: got %h want %h", obs, {8'd16, 5'b10110});
        end
        @(negedge iClock);
        iStall = 1'b1;
    endtask

    task automatic test_int();
        iIntPending = 1'b1;
        iIme        = 1'b1;
        #1;
        n_cmp++;
        if (oIntAck !== 1'b0) begin
            n_err++;
            $display("FAIL int_stalled: ack=%b want 0", oIntAck);
        end
        iStall = 1'b0;
        #1;
        n_cmp++;
        if (obs[4:0] !== 5'b00001) begin
            n_err++;
            $display("FAIL int_ack: strb=%b want 00001", obs[4:0]);
        end
        @(negedge iClock);
        iIntPending = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {8'd202, 5'b10010}) begin
            n_err++;
            $display("FAIL int_flow: got %h want %h", obs, {8'd202, 5'b10010});
        end
        @(negedge iClock);
        iStall = 1'b1;
    endtask

    task automatic test_int_masked();
        logic [12:0] ex [4];
        ex = '{{8'd1, 5'b11000}, {8'd2, 5'b11000},
               {8'd3, 5'b10000}, {8'd4, 5'b11010}};
        iIntPending = 1'b1;
        iIme        = 1'b0;
        iMemData    = 8'h31;
        iStall      = 1'b0;
        #1;
        n_cmp++;
        if (oIntAck !== 1'b0) begin
            n_err++;
            $display("FAIL int_masked_ack: ack=%b want 0", oIntAck);
        end
        @(negedge iClock);
        n_cmp++;
        if (oMop !== 8'h31 || obs[4:0] !== 5'b0) begin
            n_err++;
            $display("FAIL int_masked_latch: mop=%h strb=%b want 31 00000", oMop, obs[4:0]);
        end
        @(negedge iClock);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== ex[i]) begin
                n_err++;
                $display("FAIL int_masked[%0d]: got %h want %h", i, obs, ex[i]);
            end
            @(negedge iClock);
        end
        iStall      = 1'b1;
        iIntPending = 1'b0;
    endtask

    task automatic test_stall();
        start(8'h31);
        @(negedge iClock);
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (obs !== {8'd2, 5'b0} || oUop !== 13'd0) begin
                n_err++;
                $display("FAIL stall[%0d]: got %h uop=%h want %h 0000", i, obs, oUop, {8'd2, 5'b0});
            end
            @(negedge iClock);
        end
        iStall = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {8'd2, 5'b11000}) begin
            n_err++;
            $display("FAIL stall_resume2: got %h want %h", obs, {8'd2, 5'b11000});
        end
        @(negedge iClock);
        n_cmp++;
        if (obs !== {8'd3, 5'b10000}) begin
            n_err++;
            $display("FAIL stall_resume3: got %h want %h", obs, {8'd3, 5'b10000});
        end
        @(negedge iClock);
        n_cmp++;
        if (obs !== {8'd4, 5'b11010}) begin
            n_err++;
            $display("FAIL stall_resume4: got %h want %h", obs, {8'd4, 5'b11010});
        end
        @(negedge iClock);
        iStall = 1'b1;
    endtask

    task automatic test_fault();
        start(8'h40);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if ({oFault, obs} !== {1'b0, 8'(100 + i), 5'b10000}) begin
                n_err++;
                $display("FAIL fault_run[%0d]: got %b_%h want 0_%h", i, oFault, obs,
                         {8'(100 + i), 5'b10000});
            end
            @(negedge iClock);
        end
        n_cmp++;
        if ({oFault, obs} !== {1'b1, 8'd131, 5'b0}) begin
            n_err++;
            $display("FAIL fault_set: got %b_%h want 1_%h", oFault, obs, {8'd131, 5'b0});
        end
        @(negedge iClock);
        @(negedge iClock);
        n_cmp++;
        if ({oFault, obs} !== {1'b1, 8'd100, 5'b10000}) begin
            n_err++;
            $display("FAIL fault_sticky: got %b_%h want 1_%h", oFault, obs, {8'd100, 5'b10000});
        end
        iReset = 1'b1;
        #1;
        n_cmp++;
        if ({oFault, oRomAddr, oMop, obs[4:0]} !== 22'd0) begin
            n_err++;
            $display("FAIL async_reset: fault=%b addr=%h mop=%h strb=%b want 0",
                     oFault, oRomAddr, oMop, obs[4:0]);
        end
        iStall = 1'b1;
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        n_cmp++;
        if (oFault !== 1'b0 || oRomAddr !== 8'd0) begin
            n_err++;
            $display("FAIL post_reset: fault=%b addr=%h want 0 00", oFault, oRomAddr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 13'd0;
            lut[i]   = 8'd0;
            cblut[i] = 8'd0;
        end
        lut[8'h31]   = 8'd1;
        lut[8'h20]   = 8'd17;
        lut[8'hCB]   = 8'd13;
        lut[8'h40]   = 8'd100;
        cblut[8'h7C] = 8'd16;
        rom[1]   = u(4'd1, 5'd0);
        rom[2]   = u(4'd1, 5'd0);
        rom[3]   = u(4'd0, 5'd0);
        rom[4]   = u(4'd3, 5'd0);
        rom[13]  = u(4'd1, 5'd0);
        rom[14]  = u(4'd0, 5'd0);
        rom[15]  = u(4'd1, 5'd1);
        rom[16]  = u(4'd4, 5'd0);
        rom[17]  = u(4'd1, 5'd0);
        rom[18]  = u(4'd0, 5'd0);
        rom[19]  = u(4'd6, 5'd0);
        rom[20]  = u(4'd0, 5'd0);
        rom[21]  = u(4'd0, 5'd0);
        rom[22]  = u(4'd2, 5'd0);
        rom[202] = u(4'd2, 5'd0);

        iReset      = 1'b1;
        iStall      = 1'b1;
        iMemData    = 8'h00;
        iZFlag      = 1'b0;
        iIntPending = 1'b0;
        iIme        = 1'b0;
        @(negedge iClock);

        test_reset();
        test_basic();
        test_jrnz(1'b1);
        test_jrnz(1'b0);
        test_cb();
        test_int();
        test_int_masked();
        test_stall();
        test_fault();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
